// File: rtl/tester_flags_pkg.sv
// Shared jump-type and condition codes for the branch-decision unit.
// Constants only: no latency, no flow control.
package tester_flags_pkg;

  localparam logic [2:0] OP_JF  = 3'b000;
  localparam logic [2:0] OP_JT  = 3'b001;
  localparam logic [2:0] OP_J   = 3'b010;
  localparam logic [2:0] OP_JAL = 3'b011;
  localparam logic [2:0] OP_JR  = 3'b100;
  localparam logic [2:0] OP_NOJ = 3'b111;

  localparam logic [2:0] COND_TRUE     = 3'b000;
  localparam logic [2:0] COND_NEG      = 3'b001;
  localparam logic [2:0] COND_ZERO     = 3'b010;
  localparam logic [2:0] COND_CARRY    = 3'b100;
  localparam logic [2:0] COND_NEGZERO  = 3'b101;
  localparam logic [2:0] COND_OVERFLOW = 3'b111;

endpackage

// File: rtl/tester_flags_cond.sv
// Maps the condition selector and ALU flags to a single condition value.
// Combinational, zero latency; no flow control.
module tester_flags_cond
  import tester_flags_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       O,
  input  logic       S,
  input  logic       C,
  input  logic       Z,
  output logic       cv
);

  always_comb begin
    cv = 1'b0;
    case (cond)
      COND_TRUE:     cv = 1'b1;
      COND_NEG:      cv = S;
      COND_ZERO:     cv = Z;
      COND_CARRY:    cv = C;
      COND_NEGZERO:  cv = S & Z;
      COND_OVERFLOW: cv = O;
      // 011 and 110 are reserved and never satisfied
      default:       cv = 1'b0;
    endcase
  end

endmodule

// File: rtl/tester_flags.sv
// Branch decision: active-low jump select (0 = take jump) from flags, cond and OP_TF.
// Latency 0 combinational; 1 cycle when TESTER_FLAGS_REG_OUT_EN is defined. No backpressure.
module tester_flags
  import tester_flags_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       O,
  input  logic       S,
  input  logic       C,
  input  logic       Z,
  input  logic [2:0] cond,
  input  logic [2:0] OP_TF,
  output logic       out
);

  logic cv;
  logic jmp;

  tester_flags_cond u_cond (
    .cond (cond),
    .O    (O),
    .S    (S),
    .C    (C),
    .Z    (Z),
    .cv   (cv)
  );

  always_comb begin
    jmp = 1'b0;
    case (OP_TF)
      OP_JF:              jmp = ~cv;
      OP_JT:              jmp = cv;
      OP_J, OP_JAL, OP_JR: jmp = 1'b1;
      default:            jmp = 1'b0;
    endcase
  end

`ifdef TESTER_FLAGS_REG_OUT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      out <= 1'b1;
    end else begin
      out <= ~jmp;
    end
  end
`else
  logic unused_clk;
  assign unused_clk = CLK;

  // Only a definite 1 on RESET lets a jump through; X/Z falls to the no-jump default.
  always_comb begin
    out = 1'b1;
    if (RESET == 1'b1) begin
      out = ~jmp;
    end
  end
`endif

endmodule

// File: tb/tb_tester_flags.sv
// Scoreboard bench for tester_flags: directed vectors plus a flag/cond sweep.
// Stimulus pushes expectations; a monitor pops and compares on each sample strobe.
module tb_tester_flags;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       O, S, C, Z;
  logic [2:0] cond;
  logic [2:0] OP_TF;
  logic       out;

  int checks = 0;
  int failures = 0;

  logic  exp_q[$];
  string tag_q[$];
  event  smp_ev;

  tester_flags dut (
    .CLK   (CLK),
    .RESET (RESET),
    .O     (O),
    .S     (S),
    .C     (C),
    .Z     (Z),
    .cond  (cond),
    .OP_TF (OP_TF),
    .out   (out)
  );

  always #5 CLK = ~CLK;

  // Reference written straight from the condition and jump-type tables.
  function automatic logic model_out(input logic rst, input logic o, input logic s,
                                     input logic c, input logic z,
                                     input logic [2:0] cd, input logic [2:0] op);
    logic cv, j;
    if (!rst) return 1'b1;
    cv = (cd == 3'd0) | ((cd == 3'd1) & s) | ((cd == 3'd2) & z) |
         ((cd == 3'd4) & c) | ((cd == 3'd5) & s & z) | ((cd == 3'd7) & o);
    if (op == 3'd0)      j = !cv;
    else if (op == 3'd1) j = cv;
    else                 j = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
    return !j;
  endfunction

  task automatic chk(input logic rst, input logic o, input logic s, input logic c,
                     input logic z, input logic [2:0] cd, input logic [2:0] op,
                     input logic exp, input string tag);
    RESET = rst; O = o; S = s; C = c; Z = z; cond = cd; OP_TF = op;
`ifdef TESTER_FLAGS_REG_OUT_EN
    @(posedge CLK);
`endif
    #1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    -> smp_ev;
    #1;
  endtask

  initial begin : monitor
    logic  e;
    string t;
    forever begin
      @(smp_ev);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL monitor: output sampled with empty scoreboard");
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (out !== e) begin
          failures++;
          $display("FAIL %s: out=%b expected=%b (RESET=%b OSCZ=%b%b%b%b cond=%b OP_TF=%b)",
                   t, out, e, RESET, O, S, C, Z, cond, OP_TF);
        end
      end
    end
  end

  initial begin : stim
    logic [2:0] conds [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b111};
    logic [2:0] ops   [6] = '{3'b111, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [3:0] f;
    RESET = 1'b0; O = 1'b1; S = 1'b1; C = 1'b1; Z = 1'b1; cond = 3'b000; OP_TF = 3'b010;

    // Reset state, then release with a jump opcode present.
    chk(1'b0, 1, 1, 1, 1, 3'b000, 3'b010, 1'b1, "reset_hold_j");
    chk(1'b0, 0, 0, 0, 0, 3'b000, 3'b001, 1'b1, "reset_hold_jt");
    chk(1'b1, 0, 0, 0, 0, 3'b000, 3'b010, 1'b0, "reset_release_j");

    // Hand-computed directed vectors.
    chk(1'b1, 0, 0, 0, 0, 3'b000, 3'b000, 1'b1, "jf_true");
    chk(1'b1, 0, 0, 0, 0, 3'b001, 3'b000, 1'b0, "jf_neg_s0");
    chk(1'b1, 0, 1, 0, 0, 3'b001, 3'b000, 1'b1, "jf_neg_s1");
    chk(1'b1, 0, 1, 0, 1, 3'b101, 3'b000, 1'b1, "jf_negzero_s1z1");
    chk(1'b1, 0, 1, 0, 0, 3'b101, 3'b000, 1'b0, "jf_negzero_s1z0");
    chk(1'b1, 0, 1, 1, 1, 3'b111, 3'b000, 1'b0, "jf_ovf_o0");
    chk(1'b1, 0, 0, 0, 0, 3'b000, 3'b001, 1'b0, "jt_true");
    chk(1'b1, 0, 0, 0, 1, 3'b010, 3'b001, 1'b0, "jt_zero_z1");
    chk(1'b1, 1, 1, 1, 0, 3'b010, 3'b001, 1'b1, "jt_zero_z0");
    chk(1'b1, 0, 0, 1, 0, 3'b100, 3'b001, 1'b0, "jt_carry_c1");
    chk(1'b1, 0, 1, 1, 1, 3'b111, 3'b001, 1'b1, "jt_ovf_o0");
    chk(1'b1, 1, 0, 0, 0, 3'b111, 3'b001, 1'b0, "jt_ovf_o1");
    chk(1'b1, 1, 1, 1, 1, 3'b011, 3'b001, 1'b1, "jt_reserved_011");
    chk(1'b1, 1, 1, 1, 1, 3'b011, 3'b000, 1'b0, "jf_reserved_011");
    chk(1'b1, 1, 1, 1, 1, 3'b110, 3'b001, 1'b1, "jt_reserved_110");
    chk(1'b1, 1, 1, 1, 1, 3'b000, 3'b101, 1'b1, "noj_101");
    chk(1'b1, 1, 1, 1, 1, 3'b000, 3'b110, 1'b1, "noj_110");
    chk(1'b1, 0, 0, 0, 0, 3'b011, 3'b100, 1'b0, "jr_reserved_cond");
    // Simultaneous flag and cond change on the same step.
    chk(1'b1, 0, 0, 1, 0, 3'b100, 3'b001, 1'b0, "simul_a");
    chk(1'b1, 1, 0, 0, 0, 3'b010, 3'b001, 1'b1, "simul_b");
    // Asserting reset mid-stream overrides a taken jump.
    chk(1'b0, 0, 0, 0, 0, 3'b000, 3'b011, 1'b1, "reset_reassert_jal");

    // Full flag sweep against every defined cond for each jump type.
    foreach (ops[i]) begin
      foreach (conds[k]) begin
        for (int n = 0; n < 16; n++) begin
          f = n[3:0];
          chk(1'b1, f[3], f[2], f[1], f[0], conds[k], ops[i],
              model_out(1'b1, f[3], f[2], f[1], f[0], conds[k], ops[i]),
              $sformatf("sweep_op%0d_cond%0d_oscz%0d", ops[i], conds[k], n));
        end
      end
    end

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
